ysyx_041461_if_fetch: RTL and testbench
=======================================

Name: ysyx_041461_if_fetch

Overview:
Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC and issues one AXI4-Lite read per instruction.
- Extracts the 32-bit instruction from the 64-bit read beat.
- Presents {pc, inst, fault} to ID with a valid/ready handshake.
- Drives the PC register's enable, so the PC advances only when an instruction is handed to ID or a redirect/flush occurs.

Parameters:
ADDR_W, 32, AXI address width; araddr_o = pc_i[ADDR_W-1:0] with bits [2:0] forced to 0.
DATA_W, 64, AXI read data width; fixed at 64, instruction half selected by pc[2].

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
pc_i  in  64  current PC from PC register
flush_i  in  1  redirect/flush from ID or WB (branch, trap, mret)
pc_enable_o  out  1  enable to PC register
araddr_o  out  ADDR_W  AXI AR address
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
rdata_i  in  DATA_W  AXI R data
rresp_i  in  2  AXI R response
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
id_valid_o  out  1  instruction valid to ID
id_ready_i  in  1  ID accepts instruction
id_pc_o  out  64  PC of presented instruction
id_inst_o  out  32  instruction word
id_fault_o  out  1  fetch fault (misaligned PC or rresp != 0)

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; drop flag = 0.
  - fetch_pc, id_pc_o, id_inst_o, id_fault_o = 0.
  - arvalid_o, rready_o, id_valid_o, pc_enable_o = 0.
  - Reset mid-transaction abandons the AXI transaction; the bus shares the reset.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - Gives the PC register one cycle to settle after an update.
  - Next state is ADDR if flush_i=0; otherwise stays IDLE.
  - On leaving, latch fetch_pc = pc_i.
- Misaligned PC: if pc_i[1:0] != 0 when leaving IDLE, go directly to HOLD with id_fault_o=1 and id_inst_o=0. No bus access.
- ADDR:
  - arvalid_o=1; araddr_o = {fetch_pc[ADDR_W-1:3], 3'b000}, held stable until arready_i.
  - arvalid_o is never deasserted before the handshake, even under flush.
  - On arvalid_o & arready_i, go to DATA.
- DATA:
  - rready_o=1.
  - On rvalid_i, capture id_inst_o = fetch_pc[2] ? rdata_i[63:32] : rdata_i[31:0] and id_fault_o = (rresp_i != 2'b00).
  - Then go to HOLD, or to IDLE if drop=1 or flush_i=1 that cycle.
- HOLD:
  - id_valid_o = ~flush_i; id_pc_o = fetch_pc.
  - Outputs stay stable while id_ready_i=0.
  - On id_valid_o & id_ready_i, go to IDLE.
  - On flush_i, go to IDLE and discard the instruction.
- drop flag:
  - Set when flush_i=1 in ADDR or in DATA without rvalid_i.
  - Cleared when the R beat completes.
  - A dropped beat is consumed (rready_o=1) but never presented to ID.
- pc_enable_o is combinational: (state==HOLD & id_ready_i & ~flush_i) | flush_i.
  - Exactly one pulse per accepted instruction.
  - Also high on every flush cycle, so PC-register redirects take effect.
- Simultaneous events:
  - flush_i with id_ready_i in HOLD: flush wins; no handoff; pc_enable_o=1.
  - flush_i with rvalid_i in DATA: the beat is dropped.
- Throughput: with a zero-wait slave (arready=1, rvalid one cycle after AR), IDLE→ADDR→DATA→HOLD is 4 cycles per instruction. Backpressure from ID or the bus extends the corresponding state.
- Only one outstanding AR at a time; no new AR until the R beat returns.

Test Plan:
1. Reset release, pc_i=0x3000_0000, zero-wait slave returning rdata=0x0000_0013_0000_0093, id_ready=1 → araddr=0x3000_0000 in cycle 2; id_inst=0x0000_0093, id_pc=0x3000_0000, id_valid in cycle 4; pc_enable pulses in cycle 4.
2. pc_i=0x3000_0004, same rdata → id_inst=0x0000_0013; araddr=0x3000_0000.
3. id_ready held 0 for 5 cycles in HOLD → id_valid, id_pc, id_inst stable; pc_enable=0 throughout; single pulse when ready rises.
4. arready delayed 3 cycles with flush_i pulsed in the first ADDR cycle → arvalid stays 1 and araddr stays stable until the handshake; R beat consumed, id_valid never asserted; pc_enable=1 in the flush cycle; next fetch uses the new pc_i.
5. rresp=2'b10 on the beat → id_fault=1; pc_i=0x3000_0002 → no AR issued, id_fault=1, id_inst=0.
6. rst_n asserted in DATA state → all outputs 0 immediately (async); after release, fetch restarts from IDLE.

Source files
------------

// File: rtl/ysyx_041461_if_fetch_if.sv
// Fetch-stage bundle: AXI4-Lite read channels towards memory plus the
// valid/ready instruction handoff towards ID.
interface ysyx_041461_if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic              id_valid;
  logic              id_ready;
  logic [63:0]       id_pc;
  logic [31:0]       id_inst;
  logic              id_fault;

  modport master (
    output araddr, arvalid, rready, id_valid, id_pc, id_inst, id_fault,
    input  arready, rdata, rresp, rvalid, id_ready
  );

  modport slave (
    input  araddr, arvalid, rready, id_valid, id_pc, id_inst, id_fault,
    output arready, rdata, rresp, rvalid, id_ready
  );
endinterface

// File: rtl/ysyx_041461_if_fetch.sv
// Instruction fetch: one AXI4-Lite read per PC, 32-bit word select from the
// 64-bit beat, valid/ready handoff to ID, and PC-register enable generation.
module ysyx_041461_if_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_i,
  input  logic        flush_i,
  output logic        pc_enable_o,
  ysyx_041461_if_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [63:0] fetch_pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic        misaligned;
  logic        leave_idle;
  logic        beat_done;

  assign misaligned = (pc_i[1:0] != 2'b00);
  assign leave_idle = (state_q == IDLE) && !flush_i;
  assign beat_done  = (state_q == DATA) && bus.rvalid;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: if (!flush_i) state_d = misaligned ? HOLD : ADDR;
      // AR stays up through a flush; the beat is remembered as one to discard.
      ADDR: begin
        if (flush_i)     drop_d  = 1'b1;
        if (bus.arready) state_d = DATA;
      end
      DATA: begin
        if (bus.rvalid) begin
          drop_d  = 1'b0;
          state_d = (drop_q || flush_i) ? IDLE : HOLD;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      HOLD: if (flush_i || bus.id_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      fetch_pc_q <= '0;
      inst_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (leave_idle) begin
        fetch_pc_q <= pc_i;
        if (misaligned) begin
          inst_q  <= '0;
          fault_q <= 1'b1;
        end
      end
      if (beat_done) begin
        inst_q  <= fetch_pc_q[2] ? bus.rdata[DATA_W-1 -: 32] : bus.rdata[31:0];
        fault_q <= (bus.rresp != 2'b00);
      end
    end
  end

  assign bus.araddr   = {fetch_pc_q[ADDR_W-1:3], 3'b000};
  assign bus.arvalid  = (state_q == ADDR);
  assign bus.rready   = (state_q == DATA);
  assign bus.id_valid = (state_q == HOLD) && !flush_i;
  assign bus.id_pc    = fetch_pc_q;
  assign bus.id_inst  = inst_q;
  assign bus.id_fault = fault_q;

  // Flush always enables the PC register so redirects land even mid-fetch.
  assign pc_enable_o = ((state_q == HOLD) && bus.id_ready && !flush_i) || flush_i;

endmodule

// File: tb/tb_ysyx_041461_if_fetch.sv
// Bench for ysyx_041461_if_fetch: PC-register model, memory slave with
// programmable latency, and handoff checks derived from a memory image.
module tb_ysyx_041461_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic        flush;
  logic        pc_enable;

  ysyx_041461_if_fetch_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ysyx_041461_if_fetch #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .flush_i(flush),
    .pc_enable_o(pc_enable), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, last_prog = 0;
  logic [63:0] pc_reg;
  bit          r_pend, ar_prev, hold_prev, prev_arvalid;
  int          r_cnt, r_wait, ar_wait, ar_cnt;
  logic [31:0] r_addr, ar_addr_prev, h_inst, ar_issue_addr, acc_inst;
  logic [63:0] h_pc, acc_pc;
  logic        h_fault, acc_fault;
  int          n_acc, acc_cyc, n_ar, ar_issue_cyc, en_count, last_en_cyc, n_valid;

  // Memory image: region 3 holds a fixed addi pair, region 4 answers SLVERR.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a[31:28] == 4'h3) return 64'h0000_0013_0000_0093;
    return {a ^ 32'hdead_beef, ~a + 32'h1357_9bdf};
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a[31:28] == 4'h4) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
    logic [63:0] w;
    if (p[1:0] != 2'b00) return 32'h0;
    w = mem_word({p[31:3], 3'b000});
    return p[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic logic exp_fault(input logic [63:0] p);
    return (p[1:0] != 2'b00) || (mem_resp({p[31:3], 3'b000}) != 2'b00);
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    logic [3:0]  r;
    case ($urandom_range(0, 2))
      0:       r = 4'h3;
      1:       r = 4'h4;
      default: r = 4'h8;
    endcase
    t[63:32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
    t[31:0]  = {r, 16'h0, 12'($urandom_range(0, 4095)) & 12'hffc};
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    r_pend = 0; r_cnt = 0; ar_cnt = 0;
    ar_prev = 0; hold_prev = 0; prev_arvalid = 0;
  endtask

  // One clock: drive inputs, check combinational view, then advance models.
  task automatic cycle(input logic fl, input logic idr, input logic [63:0] target);
    logic acc, arhs, rhs, en;
    cyc++;
    flush        = fl;
    bus.id_ready = idr;
    pc           = pc_reg;
    bus.arready  = (ar_cnt >= ar_wait);
    if (r_pend && r_cnt >= r_wait) begin
      bus.rvalid = 1'b1;
      bus.rdata  = mem_word(r_addr);
      bus.rresp  = mem_resp(r_addr);
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = {$urandom, $urandom};
      bus.rresp  = 2'($urandom_range(0, 3));
    end
    #1;
    if (fl) begin
      check("pc_enable_on_flush", pc_enable, 1);
      check("id_valid_under_flush", bus.id_valid, 0);
    end else begin
      check("pc_enable_vs_accept", pc_enable, bus.id_valid & idr);
    end
    check("rready_vs_pending", bus.rready, r_pend);
    if (r_pend) check("ar_while_r_pending", bus.arvalid, 0);
    if (ar_prev) begin
      check("arvalid_held", bus.arvalid, 1);
      check("araddr_held", bus.araddr, ar_addr_prev);
    end
    if (bus.arvalid && !prev_arvalid) begin
      n_ar++;
      ar_issue_cyc  = cyc;
      ar_issue_addr = bus.araddr;
      check("araddr_at_issue", bus.araddr, {pc_reg[31:3], 3'b000});
      check("ar_pc_low_bits", pc_reg[1:0], 2'b00);
    end
    if (hold_prev && !fl) begin
      check("hold_valid", bus.id_valid, 1);
      check("hold_pc", bus.id_pc, h_pc);
      check("hold_inst", bus.id_inst, h_inst);
      check("hold_fault", bus.id_fault, h_fault);
    end
    if (bus.id_valid) n_valid++;
    acc = bus.id_valid & idr;
    if (acc) begin
      n_acc++;
      acc_cyc = cyc; acc_pc = bus.id_pc; acc_inst = bus.id_inst; acc_fault = bus.id_fault;
      check("handoff_pc", bus.id_pc, pc_reg);
      check("handoff_inst", bus.id_inst, exp_inst(pc_reg));
      check("handoff_fault", bus.id_fault, exp_fault(pc_reg));
    end
    en = pc_enable;
    if (en) begin en_count++; last_en_cyc = cyc; end
    arhs = bus.arvalid & bus.arready;
    rhs  = bus.rvalid & bus.rready;
    ar_prev      = bus.arvalid & ~bus.arready;
    ar_addr_prev = bus.araddr;
    hold_prev    = bus.id_valid & ~idr;
    h_pc = bus.id_pc; h_inst = bus.id_inst; h_fault = bus.id_fault;
    prev_arvalid = bus.arvalid;
    if (acc || fl) last_prog = cyc;
    check("progress_timeout", (cyc - last_prog) > 60, 0);
    @(posedge clk);
    #1;
    if (en) pc_reg = fl ? target : pc_reg + 64'd4;
    if (arhs) begin
      r_pend = 1; r_addr = ar_addr_prev; r_cnt = 0; ar_cnt = 0;
    end else if (ar_prev) begin
      ar_cnt++;
    end
    if (rhs) r_pend = 0;
    else if (r_pend && !arhs) r_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_enable"}, pc_enable, 0);
    check({tag, "_arvalid"}, bus.arvalid, 0);
    check({tag, "_rready"}, bus.rready, 0);
    check({tag, "_id_valid"}, bus.id_valid, 0);
    check({tag, "_id_pc"}, bus.id_pc, 0);
    check({tag, "_id_inst"}, bus.id_inst, 0);
    check({tag, "_id_fault"}, bus.id_fault, 0);
  endtask

  initial begin
    int base, en0, v0, a0, c0;
    rst_n = 1'b0; flush = 1'b0; pc_reg = 64'h3000_0000; pc = pc_reg;
    bus.id_ready = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.rdata = '0; bus.rresp = '0;
    ar_wait = 0; r_wait = 0; clear_model();
    n_acc = 0; n_ar = 0; en_count = 0; n_valid = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; last_prog = 0;

    // Zero-wait fetch of the low word.
    for (int k = 0; k < 20 && n_acc < 1; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t1_handoffs", n_acc, 1);
    check("t1_ar_cycle", ar_issue_cyc, 2);
    check("t1_araddr", ar_issue_addr, 32'h3000_0000);
    check("t1_valid_cycle", acc_cyc, 4);
    check("t1_inst", acc_inst, 32'h0000_0093);
    check("t1_pc", acc_pc, 64'h3000_0000);
    check("t1_pc_enable_cycle", last_en_cyc, 4);
    check("t1_pc_enable_count", en_count, 1);

    // High word from the same beat.
    for (int k = 0; k < 20 && n_acc < 2; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t2_handoffs", n_acc, 2);
    check("t2_araddr", ar_issue_addr, 32'h3000_0000);
    check("t2_inst", acc_inst, 32'h0000_0013);
    check("t2_pc", acc_pc, 64'h3000_0004);

    // ID backpressure for five cycles.
    for (int k = 0; k < 20 && !bus.id_valid; k++) cycle(1'b0, 1'b0, 64'h0);
    check("t3_reached_hold", bus.id_valid, 1);
    en0 = en_count; base = n_acc;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 64'h0);
      check("t3_valid_stalled", bus.id_valid, 1);
    end
    check("t3_no_enable_while_stalled", en_count, en0);
    cycle(1'b0, 1'b1, 64'h0);
    check("t3_accept", n_acc, base + 1);
    check("t3_pc", acc_pc, 64'h3000_0008);
    check("t3_single_pulse", en_count, en0 + 1);
    cycle(1'b0, 1'b1, 64'h0);
    check("t3_no_extra_pulse", en_count, en0 + 1);

    // Flush in the first ADDR cycle with a slow AR channel.
    ar_wait = 3;
    cycle(1'b1, 1'b1, 64'h3000_0100);
    check("t4_flush_in_addr", prev_arvalid, 1);
    check("t4_enable_in_flush", last_en_cyc, cyc);
    check("t4_arvalid_after_flush", bus.arvalid, 1);
    v0 = n_valid; a0 = n_ar; base = n_acc;
    for (int k = 0; k < 40 && n_ar == a0; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t4_refetch", n_ar, a0 + 1);
    check("t4_dropped_not_presented", n_valid, v0);
    ar_wait = 0;
    for (int k = 0; k < 40 && n_acc == base; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t4_accept", n_acc, base + 1);
    check("t4_new_pc", acc_pc, 64'h3000_0100);
    check("t4_new_araddr", ar_issue_addr, 32'h3000_0100);

    // Error response, then a misaligned PC.
    base = n_acc;
    cycle(1'b1, 1'b1, 64'h4000_0010);
    for (int k = 0; k < 40 && n_acc == base; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t5_accept_err", n_acc, base + 1);
    check("t5_rresp_fault", acc_fault, 1);
    check("t5_err_pc", acc_pc, 64'h4000_0010);
    base = n_acc;
    cycle(1'b1, 1'b1, 64'h3000_0002);
    a0 = n_ar;
    for (int k = 0; k < 40 && n_acc == base; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t5_accept_misaligned", n_acc, base + 1);
    check("t5_no_ar", n_ar, a0);
    check("t5_misaligned_fault", acc_fault, 1);
    check("t5_misaligned_inst", acc_inst, 32'h0);
    check("t5_misaligned_pc", acc_pc, 64'h3000_0002);

    // Asynchronous reset while waiting for the R beat.
    r_wait = 3;
    cycle(1'b1, 1'b1, 64'h3000_0010);
    for (int k = 0; k < 20 && !bus.rready; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t6_in_data", bus.rready, 1);
    rst_n = 1'b0;
    bus.rvalid = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_wait = 0; c0 = cyc; last_prog = cyc; base = n_acc;
    for (int k = 0; k < 40 && n_acc == base; k++) cycle(1'b0, 1'b1, 64'h0);
    check("t6_accept", n_acc, base + 1);
    check("t6_restart_ar_cycle", ar_issue_cyc, c0 + 2);
    check("t6_pc", acc_pc, 64'h3000_0010);
    check("t6_inst", acc_inst, 32'h0000_0093);

    // Randomized traffic: flushes, ID backpressure, bus latency.
    base = n_acc;
    for (int i = 0; i < 600; i++) begin
      if (!r_pend && !prev_arvalid) begin
        ar_wait = $urandom_range(0, 2);
        r_wait  = $urandom_range(0, 2);
      end
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7, rand_target());
    end
    check("random_handoffs_seen", n_acc > base + 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
